// File: rtl/mem_reg_serial_reader_if.sv
// Serial readout bundle: start/d capture request in, bit-serial valid/ready stream and status out.
// No logic; the reader takes the master side, the consumer/bench the slave side.
// Backpressure is carried on sout_ready.
interface mem_reg_serial_reader_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] d;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, d, sout_ready,
        output sout, sout_valid, busy, done
    );

    modport slave (
        output start, d, sout_ready,
        input  sout, sout_valid, busy, done
    );
endinterface

// File: rtl/mem_reg_serial_reader.sv
// Captures a register word on start and shifts it out bit-serially; PARITY_EN appends an even-parity bit.
// Latency: first bit valid 1 cycle after start is taken; done pulses 1 cycle after the last transfer.
// Backpressure: sout/sout_valid hold while sout_ready is low, for any number of cycles.
module mem_reg_serial_reader #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_reg_serial_reader_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, PARITY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             capture;
    logic             shift;
`ifdef PARITY_EN
    logic             par_q;
`endif

    assign capture = (state == IDLE) && bus.start;
    assign shift   = (state == SHIFT) && bus.sout_ready;

    always_comb begin
        state_nxt      = state;
        bus.sout_valid = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bus.sout_valid = 1'b1;
                bus.busy       = 1'b1;
                if (bus.sout_ready && (cnt == CW'(WIDTH - 1))) begin
`ifdef PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                bus.sout_valid = 1'b1;
                bus.busy       = 1'b1;
                bus.sout       = par_q;
                if (bus.sout_ready) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                // Unused encodings recover to IDLE with everything quiet.
                bus.sout  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (capture) begin
                sreg  <= bus.d;
                cnt   <= '0;
`ifdef PARITY_EN
                par_q <= ^bus.d;
`endif
            end else if (shift) begin
                // Zero fill leaves sout low once the word is drained.
                sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                cnt  <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_reg_serial_reader.sv
// Drives an MSB-first and an LSB-first reader with identical stimulus and checks both streams.
module tb_mem_reg_serial_reader;
    localparam int W = 16;
`ifdef PARITY_EN
    localparam int NX = W + 1;
`else
    localparam int NX = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] din = '0;
    int           n_cmp = 0;
    int           n_err = 0;

    mem_reg_serial_reader_if #(.WIDTH(W)) bus_m ();
    mem_reg_serial_reader_if #(.WIDTH(W)) bus_l ();

    assign bus_m.start      = start;
    assign bus_m.d          = din;
    assign bus_m.sout_ready = ready;
    assign bus_l.start      = start;
    assign bus_l.d          = din;
    assign bus_l.sout_ready = ready;

    mem_reg_serial_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
    mem_reg_serial_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge after the done pulse.
    task automatic run_frame(input string tag, input logic [W-1:0] word, input logic [W-1:0] exp,
                             input logic exp_par, input bit bp, input bit hold, input bit clobber);
        logic         bm [0:W];
        logic         bl [0:W];
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        logic         psm;
        logic         psl;
        int           nx;
        int           vcyc;
        int           ri;
        int           cyc;
        bit           fin;
        bit           stall;
        nx = 0; vcyc = 0; ri = 0; fin = 1'b0; stall = 1'b0; psm = 1'b0; psl = 1'b0;
        wm = '0; wl = '0;
        for (int i = 0; i <= W; i++) begin
            bm[i] = 1'b0;
            bl[i] = 1'b0;
        end
        din   = word;
        start = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (clobber) din = '0;
        for (cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (bus_m.done) begin
                fin = 1'b1;
                check({tag, " done cycle"}, cyc, vcyc);
                check({tag, " done state"},
                      {bus_m.busy, bus_m.sout_valid, bus_l.busy, bus_l.sout_valid, bus_l.done},
                      5'b00001);
            end else begin
                if (cyc == 0)
                    check({tag, " first bit"},
                          {bus_m.sout_valid, bus_m.busy, bus_l.sout_valid, bus_l.busy, bus_m.sout, bus_l.sout},
                          {4'hF, exp[W-1], exp[0]});
                if (stall)
                    check({tag, " stall hold"},
                          {bus_m.sout_valid, bus_m.sout, bus_l.sout_valid, bus_l.sout},
                          {1'b1, psm, 1'b1, psl});
                if (bus_m.sout_valid) vcyc++;
                ready = bp ? ((ri % 4 == 0) || (ri % 4 == 3)) : 1'b1;
                ri++;
                stall = bus_m.sout_valid && !ready;
                psm   = bus_m.sout;
                psl   = bus_l.sout;
                if (bus_m.sout_valid && ready) begin
                    if (nx <= W) begin
                        bm[nx] = bus_m.sout;
                        bl[nx] = bus_l.sout;
                    end
                    nx++;
                end
                @(negedge clk);
            end
        end
        check({tag, " done seen"}, fin, 1);
        check({tag, " transfers"}, nx, NX);
        for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bm[i];
            wl[i]     = bl[i];
        end
        check({tag, " msb stream"}, wm, exp);
        check({tag, " lsb stream"}, wl, exp);
`ifdef PARITY_EN
        check({tag, " parity bit"}, {bm[W], bl[W]}, {exp_par, exp_par});
`endif
        @(negedge clk);
        check({tag, " single done"},
              {bus_m.done, bus_m.sout_valid, bus_m.busy, bus_l.done, bus_l.sout_valid}, 5'b0);
    endtask

    initial begin
        bit any_bad;
        bit fin;
        any_bad = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs",
              {bus_m.sout, bus_m.sout_valid, bus_m.busy, bus_m.done,
               bus_l.sout, bus_l.sout_valid, bus_l.busy, bus_l.done}, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("idle after reset", {bus_m.sout_valid, bus_m.busy, bus_m.done}, 3'b000);

        run_frame("basic", 16'hA5C3, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("lsb one", 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("backpressure", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("bp msb", 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0);

        // start held and d cleared after capture: frame unaffected, restart only from IDLE.
        run_frame("hold", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("restart from idle", {bus_m.sout_valid, bus_m.busy, bus_m.sout, bus_l.sout}, 4'b1100);
        start = 1'b0;
        ready = 1'b1;
        fin   = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (bus_m.done) fin = 1'b1;
            else @(negedge clk);
        end
        check("restart drained", fin, 1);
        @(negedge clk);

        // Reset mid-frame after 5 transfers.
        din   = 16'h1234;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset busy", {bus_m.sout_valid, bus_m.busy}, 2'b11);
        #2 rst = 1'b0;
        #1 check("reset mid frame",
                 {bus_m.sout, bus_m.sout_valid, bus_m.busy, bus_m.done,
                  bus_l.sout, bus_l.sout_valid, bus_l.busy, bus_l.done}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus_m.done || bus_m.sout_valid || bus_m.busy || bus_l.done || bus_l.sout_valid)
                any_bad = 1'b1;
        end
        check("quiet after reset", any_bad, 0);
        run_frame("fresh", 16'h5A3C, 16'h5A3C, 1'b0, 1'b0, 1'b0, 1'b0);

        run_frame("par seven", 16'h0007, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("par three", 16'h0003, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
